status_irq_arbiter: RTL and testbench

Parametrised successor to the fixed 8-bit status register and 8-to-3 priority encoder.
- Latches NUM_SRC status flags into sticky pending bits and applies a writable per-source mask.
- Arbitrates highest-index-wins among unmasked pending sources.
- Presents the winner on a valid/ack handshake and clears that pending bit on acknowledge.
- Sits between peripheral status flags and the processor's interrupt/exception entry.

---
 rtl/status_irq_pkg.sv | 14 +
 rtl/prio_enc_param.sv | 23 ++
 rtl/status_irq_arbiter.sv | 82 ++++++++
 tb/tb_status_irq_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/status_irq_pkg.sv
// rtl/status_irq_pkg.sv - shared types and width helper for the status interrupt arbiter
package status_irq_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Index width; a single-bit index is kept even for degenerate source counts
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_enc_param.sv
// rtl/prio_enc_param.sv - combinational highest-index-wins priority encoder
module prio_enc_param #(
  parameter int NUM_SRC = 16,
  parameter int ID_W    = 4
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [ID_W-1:0]    idx,
  output logic               found
);

  // Ascending scan: the last set bit visited is the highest index
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i]) begin
        idx   = ID_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/status_irq_arbiter.sv
// rtl/status_irq_arbiter.sv - sticky status flags with mask, priority arbitration and valid/ack handshake
module status_irq_arbiter
  import status_irq_pkg::*;
#(
  parameter int                 NUM_SRC  = 16,
  parameter int                 ID_W     = id_width(NUM_SRC),
  parameter logic [NUM_SRC-1:0] MASK_RST = '1
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic [NUM_SRC-1:0] flags_in,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               irq_ack,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  output logic               any_pending
);

  state_t             state;
  state_t             state_next;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] clr_vec;
  logic [ID_W-1:0]    win_idx;
  logic               win_found;
  logic               ack_fire;

  assign eligible    = pending & mask;
  assign any_pending = |eligible;
  assign ack_fire    = (state == PRESENT) && irq_ack;

  prio_enc_param #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req   (eligible),
    .idx   (win_idx),
    .found (win_found)
  );

  always_comb begin
    clr_vec = '0;
    if (ack_fire) clr_vec = NUM_SRC'(1) << irq_id;
  end

  // New flags are OR-ed after the clear so a same-cycle re-set survives the ack
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pending <= '0;
      mask    <= MASK_RST;
    end else begin
      pending <= (pending & ~clr_vec) | flags_in;
      if (mask_we) mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state  <= IDLE;
      irq_id <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && win_found) irq_id <= win_idx;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found) state_next = PRESENT;
      PRESENT: if (irq_ack)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    irq_valid = (state == PRESENT);
  end

endmodule

// File: tb/tb_status_irq_arbiter.sv
// tb/tb_status_irq_arbiter.sv - directed and randomized checks of status_irq_arbiter against a reference model
module tb_status_irq_arbiter;

  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rstN;
  logic [N-1:0]  flags_in;
  logic          mask_we;
  logic [N-1:0]  mask_wdata;
  logic          irq_ack;
  logic [N-1:0]  pending;
  logic [N-1:0]  mask;
  logic          irq_valid;
  logic [IW-1:0] irq_id;
  logic          any_pending;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] m_pend;
  logic [N-1:0] m_mask;
  bit           m_present;
  int           m_id;

  status_irq_arbiter #(.NUM_SRC(N)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .flags_in    (flags_in),
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .irq_ack     (irq_ack),
    .pending     (pending),
    .mask        (mask),
    .irq_valid   (irq_valid),
    .irq_id      (irq_id),
    .any_pending (any_pending)
  );

  always #5 clk = ~clk;

  function automatic int highest(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_pend    = '0;
    m_mask    = '1;
    m_present = 1'b0;
    m_id      = 0;
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle past the edge
  task automatic cycle(input logic [N-1:0] f, input logic ack, input logic we, input logic [N-1:0] wd);
    logic [N-1:0] elig;
    flags_in   = f;
    irq_ack    = ack;
    mask_we    = we;
    mask_wdata = wd;
    @(posedge clk);
    elig = m_pend & m_mask;
    if (m_present && ack) begin
      m_pend[m_id] = 1'b0;
      m_present    = 1'b0;
    end else if (!m_present && elig != '0) begin
      m_present = 1'b1;
      m_id      = highest(elig);
    end
    m_pend = m_pend | f;
    if (we) m_mask = wd;
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b1; flags_in = '1; mask_we = 1'b0; mask_wdata = '0; irq_ack = 1'b0;
    #1 rstN = 1'b0;
    #1;
    checks++; if (pending !== 16'h0000) begin failures++; $display("FAIL reset_pending got=%h exp=0000", pending); end
    checks++; if (mask !== 16'hFFFF) begin failures++; $display("FAIL reset_mask got=%h exp=ffff", mask); end
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", irq_valid); end
    checks++; if (irq_id !== 4'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
    model_reset();
    flags_in = '0;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_priority();
    cycle(16'h0F00, 1'b0, 1'b0, '0);
    checks++; if (pending !== 16'h0F00) begin failures++; $display("FAIL prio_pending got=%h exp=0f00", pending); end
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL prio_valid_early got=%b exp=0", irq_valid); end
    cycle('0, 1'b0, 1'b0, '0);
    checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd11) begin failures++; $display("FAIL prio_first got=%b/%0d exp=1/11", irq_valid, irq_id); end
    for (int k = 0; k < 4; k++) begin
      cycle('0, 1'b1, 1'b0, '0);
      checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL prio_gap got=%b exp=0", irq_valid); end
      checks++; if (pending !== m_pend) begin failures++; $display("FAIL prio_clear got=%h exp=%h", pending, m_pend); end
      if (k < 3) begin
        cycle('0, 1'b0, 1'b0, '0);
        checks++; if (irq_valid !== 1'b1 || irq_id !== IW'(10 - k)) begin failures++; $display("FAIL prio_next got=%b/%0d exp=1/%0d", irq_valid, irq_id, 10 - k); end
      end
    end
    cycle('0, 1'b0, 1'b0, '0);
    checks++; if (pending !== 16'h0000 || irq_valid !== 1'b0) begin failures++; $display("FAIL prio_drained got=%h/%b exp=0000/0", pending, irq_valid); end
  endtask

  task automatic test_hold();
    cycle(16'h0008, 1'b0, 1'b0, '0);
    cycle('0, 1'b0, 1'b0, '0);
    checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd3) begin failures++; $display("FAIL hold_first got=%b/%0d exp=1/3", irq_valid, irq_id); end
    cycle(16'h8000, 1'b0, 1'b0, '0);
    cycle('0, 1'b0, 1'b0, '0);
    checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd3) begin failures++; $display("FAIL hold_stable got=%b/%0d exp=1/3", irq_valid, irq_id); end
    cycle('0, 1'b1, 1'b0, '0);
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL hold_gap got=%b exp=0", irq_valid); end
    cycle('0, 1'b0, 1'b0, '0);
    checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd15) begin failures++; $display("FAIL hold_high got=%b/%0d exp=1/15", irq_valid, irq_id); end
    cycle('0, 1'b1, 1'b0, '0);
    cycle('0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_mask();
    cycle('0, 1'b0, 1'b1, 16'h00FF);
    checks++; if (mask !== 16'h00FF) begin failures++; $display("FAIL mask_write got=%h exp=00ff", mask); end
    cycle(16'h8001, 1'b0, 1'b0, '0);
    cycle('0, 1'b0, 1'b0, '0);
    checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd0) begin failures++; $display("FAIL mask_low got=%b/%0d exp=1/0", irq_valid, irq_id); end
    checks++; if (pending[15] !== 1'b1) begin failures++; $display("FAIL mask_hidden got=%b exp=1", pending[15]); end
    cycle('0, 1'b0, 1'b1, 16'hFFFF);
    checks++; if (irq_id !== 4'd0 || mask !== 16'hFFFF) begin failures++; $display("FAIL mask_reopen got=%0d/%h exp=0/ffff", irq_id, mask); end
    cycle('0, 1'b1, 1'b0, '0);
    cycle('0, 1'b0, 1'b0, '0);
    checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd15) begin failures++; $display("FAIL mask_high got=%b/%0d exp=1/15", irq_valid, irq_id); end
    cycle('0, 1'b1, 1'b0, '0);
    cycle('0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_set_over_clear();
    cycle(16'h0080, 1'b0, 1'b0, '0);
    cycle('0, 1'b0, 1'b0, '0);
    checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd7) begin failures++; $display("FAIL soc_first got=%b/%0d exp=1/7", irq_valid, irq_id); end
    cycle(16'h0080, 1'b1, 1'b0, '0);
    checks++; if (pending[7] !== 1'b1 || irq_valid !== 1'b0) begin failures++; $display("FAIL soc_keep got=%b/%b exp=1/0", pending[7], irq_valid); end
    cycle('0, 1'b0, 1'b0, '0);
    checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd7) begin failures++; $display("FAIL soc_again got=%b/%0d exp=1/7", irq_valid, irq_id); end
    cycle('0, 1'b1, 1'b0, '0);
    cycle('0, 1'b0, 1'b0, '0);
    checks++; if (pending !== 16'h0000 || irq_valid !== 1'b0) begin failures++; $display("FAIL soc_done got=%h/%b exp=0000/0", pending, irq_valid); end
  endtask

  task automatic test_reset_mid();
    cycle('0, 1'b0, 1'b1, 16'h00FF);
    cycle(16'h0020, 1'b0, 1'b0, '0);
    cycle('0, 1'b0, 1'b0, '0);
    checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd5) begin failures++; $display("FAIL rmid_first got=%b/%0d exp=1/5", irq_valid, irq_id); end
    #2 rstN = 1'b0;
    #1;
    checks++; if (pending !== 16'h0000 || mask !== 16'hFFFF) begin failures++; $display("FAIL rmid_regs got=%h/%h exp=0000/ffff", pending, mask); end
    checks++; if (irq_valid !== 1'b0 || irq_id !== 4'd0) begin failures++; $display("FAIL rmid_out got=%b/%0d exp=0/0", irq_valid, irq_id); end
    model_reset();
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle('0, 1'b0, 1'b0, '0);
      checks++; if (irq_valid !== 1'b0 || pending !== 16'h0000) begin failures++; $display("FAIL rmid_quiet got=%b/%h exp=0/0000", irq_valid, pending); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] f;
    logic [N-1:0] wd;
    logic         ack;
    logic         we;
    for (int n = 0; n < 400; n++) begin
      f   = N'($urandom & $urandom & $urandom);
      ack = 1'($urandom_range(0, 1));
      we  = ($urandom_range(0, 9) == 0);
      wd  = N'($urandom);
      cycle(f, ack, we, wd);
      checks++; if (pending !== m_pend) begin failures++; $display("FAIL rnd_pending cyc=%0d got=%h exp=%h", n, pending, m_pend); end
      checks++; if (mask !== m_mask) begin failures++; $display("FAIL rnd_mask cyc=%0d got=%h exp=%h", n, mask, m_mask); end
      checks++; if (irq_valid !== m_present) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, irq_valid, m_present); end
      checks++; if (any_pending !== (|(m_pend & m_mask))) begin failures++; $display("FAIL rnd_any cyc=%0d got=%b exp=%b", n, any_pending, |(m_pend & m_mask)); end
      if (m_present) begin
        checks++; if (irq_id !== IW'(m_id)) begin failures++; $display("FAIL rnd_id cyc=%0d got=%0d exp=%0d", n, irq_id, m_id); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_hold();
    test_mask();
    test_set_over_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
